decoder_prgm_seq: RTL and testbench

- Programming sequencer and match collector for a bank of N_DEC decoder4 slices.
- Accepts one-shot program requests (slice index + 4-bit pattern) and serializes the pattern onto the shared prgm line.
- Raises the target slice's one-hot enable for exactly 4 cycles, then marks the slice armed.
- Masks eq outputs of unarmed or not-yet-filled slices and reports lowest hitting index plus a saturating hit count.

---
 rtl/decoder_prgm_seq.sv | 115 +++++++++++
 tb/tb_decoder_prgm_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_prgm_seq.sv
// Programming sequencer and match collector for a bank of decoder4 slices.
// Serializes a 4-bit pattern MSB-first into one enabled slice, then arms it.
module decoder_prgm_seq #(
    parameter int N_DEC = 64,
    parameter int IDX_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_idx,
    input  logic [3:0]       req_pat,
    output logic             prgm,
    output logic [N_DEC-1:0] prgm_en,
    output logic             prgm_done,
    output logic             err_idx,
    output logic [N_DEC-1:0] armed,
    input  logic [N_DEC-1:0] match_in,
    output logic             match_any,
    output logic [IDX_W-1:0] match_idx,
    output logic [CNT_W-1:0] hit_count
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE, ERR} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [3:0]       pat;
    } req_t;

    localparam logic [IDX_W:0] N_LIM = (IDX_W+1)'(N_DEC);

    state_t           state;
    req_t             cur;
    logic [1:0]       k;
    logic [2:0]       warm_cnt;
    logic             warm;
    logic             idx_ok;
    logic [N_DEC-1:0] req_oh;
    logic [N_DEC-1:0] hit;
    logic [IDX_W-1:0] lo_idx;

    assign req_ready = (state == IDLE);
    assign idx_ok    = {1'b0, req_idx} < N_LIM;
    assign req_oh    = N_DEC'(1) << req_idx;
    assign warm      = (warm_cnt == 3'd4);
    assign hit       = match_in & armed & {N_DEC{warm}};

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        lo_idx = '0;
        for (int i = N_DEC - 1; i >= 0; i--)
            if (hit[i]) lo_idx = IDX_W'(i);
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= IDLE;
            cur       <= '0;
            k         <= '0;
            warm_cnt  <= '0;
            prgm      <= 1'b0;
            prgm_en   <= '0;
            prgm_done <= 1'b0;
            err_idx   <= 1'b0;
            armed     <= '0;
            match_any <= 1'b0;
            match_idx <= '0;
            hit_count <= '0;
        end else begin
            if (!warm) warm_cnt <= warm_cnt + 3'd1;

            match_any <= |hit;
            match_idx <= lo_idx;
            if (|hit && hit_count != '1) hit_count <= hit_count + CNT_W'(1);

            unique case (state)
                IDLE: if (req_valid) begin
                    cur <= '{idx: req_idx, pat: req_pat};
                    k   <= '0;
                    if (idx_ok) begin
                        state          <= SHIFT;
                        prgm           <= req_pat[3];
                        prgm_en        <= req_oh;
                        armed[req_idx] <= 1'b0;
                    end else begin
                        state   <= ERR;
                        err_idx <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (k == 2'd3) begin
                        state     <= DONE;
                        prgm      <= 1'b0;
                        prgm_en   <= '0;
                        prgm_done <= 1'b1;
                    end else begin
                        k    <= k + 2'd1;
                        prgm <= cur.pat[2'd2 - k];
                    end
                end
                DONE: begin
                    state          <= IDLE;
                    prgm_done      <= 1'b0;
                    armed[cur.idx] <= 1'b1;
                end
                ERR: begin
                    state   <= IDLE;
                    err_idx <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_decoder_prgm_seq.sv
// Scoreboard bench for decoder_prgm_seq: expected match/program results are
// queued when stimulus is driven and popped when the DUT registers its output.
module tb_decoder_prgm_seq;
    localparam int N     = 40;
    localparam int IW    = 6;
    localparam int CW    = 5;
    localparam int CMAX  = (1 << CW) - 1;

    typedef struct {
        logic          any;
        logic [IW-1:0] idx;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk = 0;
    logic          clr = 0;
    logic          req_valid = 0;
    logic          req_ready;
    logic [IW-1:0] req_idx = '0;
    logic [3:0]    req_pat = '0;
    logic          prgm;
    logic [N-1:0]  prgm_en;
    logic          prgm_done;
    logic          err_idx;
    logic [N-1:0]  armed;
    logic [N-1:0]  match_in = '0;
    logic          match_any;
    logic [IW-1:0] match_idx;
    logic [CW-1:0] hit_count;

    decoder_prgm_seq #(.N_DEC(N), .IDX_W(IW), .CNT_W(CW)) dut (
        .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
        .req_idx(req_idx), .req_pat(req_pat), .prgm(prgm), .prgm_en(prgm_en),
        .prgm_done(prgm_done), .err_idx(err_idx), .armed(armed),
        .match_in(match_in), .match_any(match_any), .match_idx(match_idx),
        .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    int           nvec = 0;
    int           nerr = 0;
    int           since_rel = 0;
    logic [N-1:0] m_armed = '0;
    logic [CW-1:0] m_count = '0;
    exp_t         exp_q[$];
    logic         prgm_q[$];

    task automatic cyc();
        @(posedge clk);
        if (!clr) since_rel = 0; else since_rel++;
        #1;
    endtask

    // Model one match cycle: queue the expected registered outputs, then compare.
    task automatic push_match(input logic [N-1:0] m);
        logic [N-1:0] h;
        exp_t e;
        h = m & m_armed & {N{since_rel >= 4}};
        e.any = |h;
        e.idx = '0;
        for (int i = N - 1; i >= 0; i--) if (h[i]) e.idx = IW'(i);
        if (e.any && m_count != CW'(CMAX)) m_count++;
        e.cnt = m_count;
        exp_q.push_back(e);
    endtask

    task automatic pop_match(input string nm);
        exp_t e;
        e = exp_q.pop_front();
        nvec++;
        if (match_any !== e.any || match_idx !== e.idx || hit_count !== e.cnt) begin
            nerr++;
            $display("FAIL %s: any/idx/cnt got %b/%0d/%0d want %b/%0d/%0d",
                     nm, match_any, match_idx, hit_count, e.any, e.idx, e.cnt);
        end
    endtask

    task automatic match_cycle(input logic [N-1:0] m, input string nm);
        match_in = m;
        push_match(m);
        cyc();
        pop_match(nm);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin cyc(); n++; end
        nvec++;
        if (req_ready !== 1'b1) begin
            nerr++;
            $display("FAIL wait_ready: req_ready got %b want 1", req_ready);
        end
    endtask

    // Program one slice; acc_m is driven on match_in during the acceptance cycle.
    task automatic do_prog(input int idx, input logic [3:0] pat, input logic [N-1:0] acc_m);
        logic [N-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        wait_ready();
        req_valid = 1;
        req_idx = IW'(idx);
        req_pat = pat;
        match_in = acc_m;
        push_match(acc_m);
        for (int b = 3; b >= 0; b--) prgm_q.push_back(pat[b]);
        cyc();
        req_valid = 0;
        match_in = '0;
        m_armed[idx] = 1'b0;
        pop_match("acc_match");
        for (int k = 0; k < 4; k++) begin
            logic eb;
            eb = prgm_q.pop_front();
            nvec++;
            if (prgm !== eb || prgm_en !== oh || req_ready !== 1'b0 || armed[idx] !== 1'b0) begin
                nerr++;
                $display("FAIL shift%0d: prgm/en/rdy/arm got %b/%h/%b/%b want %b/%h/0/0",
                         k, prgm, prgm_en, req_ready, armed[idx], eb, oh);
            end
            push_match('0);
            cyc();
            pop_match("shift_match");
        end
        nvec++;
        if (prgm_done !== 1'b1 || prgm_en !== '0 || prgm !== 1'b0 || req_ready !== 1'b0 || armed[idx] !== 1'b0) begin
            nerr++;
            $display("FAIL done: done/en/prgm/rdy/arm got %b/%h/%b/%b/%b want 1/0/0/0/0",
                     prgm_done, prgm_en, prgm, req_ready, armed[idx]);
        end
        push_match('0);
        cyc();
        pop_match("done_match");
        m_armed[idx] = 1'b1;
        nvec++;
        if (armed !== m_armed || prgm_done !== 1'b0 || req_ready !== 1'b1) begin
            nerr++;
            $display("FAIL armed: armed/done/rdy got %h/%b/%b want %h/0/1",
                     armed, prgm_done, req_ready, m_armed);
        end
    endtask

    task automatic test_reset();
        clr = 0;
        cyc();
        cyc();
        nvec++;
        if (prgm !== 0 || prgm_en !== '0 || prgm_done !== 0 || err_idx !== 0 || armed !== '0 ||
            match_any !== 0 || match_idx !== '0 || hit_count !== '0 || req_ready !== 1) begin
            nerr++;
            $display("FAIL reset: outputs not cleared (rdy=%b cnt=%0d armed=%h)",
                     req_ready, hit_count, armed);
        end
        clr = 1;
    endtask

    task automatic test_warmup();
        for (int i = 0; i < 5; i++) match_cycle({N{1'b1}}, "warmup_mask");
        match_cycle('0, "warmup_idle");
    endtask

    task automatic test_program();
        do_prog(5, 4'b1011, '0);
        do_prog(2, 4'b0110, '0);
    endtask

    task automatic test_multi_hit();
        logic [N-1:0] m;
        m = '0; m[2] = 1; m[5] = 1;
        for (int i = 0; i < 3; i++) match_cycle(m, "multi_hit");
        m = '0; m[5] = 1; m[9] = 1;
        match_cycle(m, "single_armed");
        m = '0; m[9] = 1;
        match_cycle(m, "unarmed_mask");
        match_cycle({N{1'b1}}, "all_ones");
        match_cycle('0, "no_hit");
    endtask

    task automatic test_reprogram();
        logic [N-1:0] m;
        m = '0; m[5] = 1;
        do_prog(5, 4'b0101, m);
        match_cycle(m, "rearmed_hit");
    endtask

    task automatic test_err();
        int bad[2] = '{N, 63};
        foreach (bad[j]) begin
            wait_ready();
            req_valid = 1;
            req_idx = IW'(bad[j]);
            req_pat = 4'hF;
            cyc();
            req_valid = 0;
            nvec++;
            if (err_idx !== 1 || prgm_en !== '0 || armed !== m_armed || req_ready !== 0) begin
                nerr++;
                $display("FAIL err%0d: err/en/armed/rdy got %b/%h/%h/%b want 1/0/%h/0",
                         bad[j], err_idx, prgm_en, armed, req_ready, m_armed);
            end
            cyc();
            nvec++;
            if (err_idx !== 0 || req_ready !== 1 || armed !== m_armed) begin
                nerr++;
                $display("FAIL err_end%0d: err/rdy got %b/%b want 0/1", bad[j], err_idx, req_ready);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        wait_ready();
        req_valid = 1;
        req_idx = IW'(7);
        req_pat = 4'b1010;
        cyc();
        req_valid = 0;
        cyc();
        cyc();
        clr = 0;
        cyc();
        nvec++;
        if (prgm !== 0 || prgm_en !== '0 || prgm_done !== 0 || armed !== '0 ||
            hit_count !== '0 || match_any !== 0 || req_ready !== 1) begin
            nerr++;
            $display("FAIL mid_reset: prgm/en/armed/cnt/rdy got %b/%h/%h/%0d/%b want 0/0/0/0/1",
                     prgm, prgm_en, armed, hit_count, req_ready);
        end
        clr = 1;
        m_armed = '0;
        m_count = '0;
        exp_q.delete();
        prgm_q.delete();
        cyc();
        nvec++;
        if (req_ready !== 1 || armed[7] !== 0) begin
            nerr++;
            $display("FAIL mid_release: rdy/arm7 got %b/%b want 1/0", req_ready, armed[7]);
        end
    endtask

    task automatic test_saturate();
        logic [N-1:0] m;
        m = '0; m[1] = 1;
        do_prog(1, 4'b1110, '0);
        for (int i = 0; i < CMAX + 4; i++) match_cycle(m, "sat_hit");
        nvec++;
        if (hit_count !== CW'(CMAX)) begin
            nerr++;
            $display("FAIL saturate: hit_count got %0d want %0d", hit_count, CMAX);
        end
        match_cycle('0, "sat_idle");
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_program();
        test_multi_hit();
        test_reprogram();
        test_err();
        test_reset_mid_shift();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
